pipeline_hazard_controller: RTL and testbench

//  Sequences the front end of the 16-bit pipeline: PC write-enable, IF/ID hold/flush, ID/EX bubble.

---
 rtl/pipeline_hazard_controller_pkg.sv | 35 +++
 rtl/pipeline_hazard_controller_detect.sv | 27 ++
 rtl/pipeline_hazard_controller.sv | 157 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and defaults for the pipeline front-end hazard controller.
package hazard_pkg;

  // Front-end sequencing states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } hz_state_t;

  // Decoded control bundle for the PC, IF/ID and ID/EX registers
  typedef struct packed {
    logic pcEn;
    logic fdHold;
    logic fdNop;
    logic deNop;
    logic deHold;
  } hz_ctrl_t;

  localparam int unsigned DEF_REG_ADDR_W       = 4;
  localparam int unsigned DEF_BRANCH_FLUSH_CYC = 2;
  localparam int unsigned DEF_LOAD_STALL_CYC   = 1;
  localparam int unsigned DEF_PERF_W           = 16;

  // Width of the shared down-counter; it only ever holds (cycles - 1),
  // so clog2 of the larger cycle count is enough, with a floor of one bit.
  function automatic int unsigned cntWidth(input int unsigned flushCyc,
                                           input int unsigned stallCyc);
    int unsigned maxCyc;
    maxCyc = (flushCyc > stallCyc) ? flushCyc : stallCyc;
    return (maxCyc <= 1) ? 1 : $clog2(maxCyc);
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_detect.sv
// Load-use hazard detection: flags when the Decode instruction reads a
// register that the load currently in Execute is about to write.
module hazard_detect_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] i_decRs1,
  input  logic [REG_ADDR_W-1:0] i_decRs2,
  input  logic                  i_decUseRs1,
  input  logic                  i_decUseRs2,
  input  logic [REG_ADDR_W-1:0] i_exRd,
  input  logic                  i_exMemRead,
  output logic                  o_hazard
);

  logic w_rs1Match;
  logic w_rs2Match;

  // A source only matters when the instruction really reads it
  always_comb begin
    w_rs1Match = i_decUseRs1 && (i_decRs1 == i_exRd);
    w_rs2Match = i_decUseRs2 && (i_decRs2 == i_exRd);
    o_hazard   = i_exMemRead && (w_rs1Match || w_rs2Match);
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Front-end sequencer for the 16-bit pipeline: drives the PC enable and the
// IF/ID and ID/EX hold/bubble controls, resolving load-use stalls, taken
// branch flushes and data-memory freezes, and keeps saturating perf counters.
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W       = DEF_REG_ADDR_W,
  parameter int unsigned BRANCH_FLUSH_CYC = DEF_BRANCH_FLUSH_CYC,
  parameter int unsigned LOAD_STALL_CYC   = DEF_LOAD_STALL_CYC,
  parameter int unsigned PERF_W           = DEF_PERF_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  fd_hold,
  output logic                  fd_nop,
  output logic                  de_nop,
  output logic                  de_hold,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
);

  localparam int unsigned        CNT_W      = cntWidth(BRANCH_FLUSH_CYC, LOAD_STALL_CYC);
  localparam logic [CNT_W-1:0]   FLUSH_LOAD = CNT_W'(BRANCH_FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0]   STALL_LOAD = CNT_W'(LOAD_STALL_CYC - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [PERF_W-1:0]  PERF_ONE   = PERF_W'(1);
  localparam logic [PERF_W-1:0]  PERF_MAX   = '1;

  hz_state_t         r_state;
  hz_state_t         w_nextState;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_nextCnt;
  logic              w_hazard;
  hz_ctrl_t          w_ctrl;
  logic [PERF_W-1:0] r_stallCnt;
  logic [PERF_W-1:0] r_flushCnt;

  hazard_detect_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .i_decRs1    (dec_rs1),
    .i_decRs2    (dec_rs2),
    .i_decUseRs1 (dec_use_rs1),
    .i_decUseRs2 (dec_use_rs2),
    .i_exRd      (ex_rd),
    .i_exMemRead (ex_mem_read),
    .o_hazard    (w_hazard)
  );

  // State register and shared down-counter; reset discards any pending work
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Next state: branch beats memory freeze beats load-use stall beats the state's own sequencing
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    if (ex_branch_taken) begin
      w_nextCnt   = FLUSH_LOAD;
      w_nextState = (FLUSH_LOAD != '0) ? FLUSH : RUN;
    end else if (mem_busy) begin
      w_nextCnt   = '0;
      w_nextState = FREEZE;
    end else if (w_hazard) begin
      w_nextCnt   = STALL_LOAD;
      w_nextState = (STALL_LOAD != '0) ? STALL : RUN;
    end else begin
      case (r_state)
        STALL, FLUSH: begin
          if (r_cnt <= CNT_ONE) begin
            w_nextCnt   = '0;
            w_nextState = RUN;
          end else begin
            w_nextCnt   = r_cnt - CNT_ONE;
            w_nextState = r_state;
          end
        end
        default: begin
          w_nextCnt   = '0;
          w_nextState = RUN;
        end
      endcase
    end
  end

  // Output decode from state and live inputs so hazards and branches act in the same cycle
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.pcEn   = 1'b1;
    if (!reset) begin
      w_ctrl.pcEn   = 1'b0;
      w_ctrl.fdNop  = 1'b1;
      w_ctrl.deNop  = 1'b1;
    end else if (ex_branch_taken) begin
      w_ctrl.pcEn   = 1'b1;
      w_ctrl.fdNop  = 1'b1;
      w_ctrl.deNop  = 1'b1;
    end else if (mem_busy) begin
      w_ctrl.pcEn   = 1'b0;
      w_ctrl.fdHold = 1'b1;
      w_ctrl.deHold = 1'b1;
    end else if (w_hazard || (r_state == STALL)) begin
      w_ctrl.pcEn   = 1'b0;
      w_ctrl.fdHold = 1'b1;
      w_ctrl.deNop  = 1'b1;
    end else if (r_state == FLUSH) begin
      w_ctrl.pcEn   = 1'b1;
      w_ctrl.fdNop  = 1'b1;
    end
  end

  // Saturating performance counters: held cycles count as stalls, nop-loaded IF/ID cycles as flushes
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_ctrl.fdHold && (r_stallCnt != PERF_MAX)) begin
        r_stallCnt <= r_stallCnt + PERF_ONE;
      end
      if (w_ctrl.fdNop && (r_flushCnt != PERF_MAX)) begin
        r_flushCnt <= r_flushCnt + PERF_ONE;
      end
    end
  end

  assign pc_en     = w_ctrl.pcEn;
  assign fd_hold   = w_ctrl.fdHold;
  assign fd_nop    = w_ctrl.fdNop;
  assign de_nop    = w_ctrl.deNop;
  assign de_hold   = w_ctrl.deHold;
  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

  // A register is never asked to hold and load a nop at the same time
  always_ff @(posedge clk) begin
    assert (!(w_ctrl.fdHold && w_ctrl.fdNop));
    assert (!(w_ctrl.deHold && w_ctrl.deNop));
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller: a default instance plus a
// long-stall, narrow-counter instance sharing the same input stimulus.
module tb_pipeline_hazard_controller;

  logic        clk;
  logic        reset;
  logic [3:0]  decRs1;
  logic [3:0]  decRs2;
  logic        decUseRs1;
  logic        decUseRs2;
  logic [3:0]  exRd;
  logic        exMemRead;
  logic        exBranchTaken;
  logic        memBusy;

  logic        pcEn, fdHold, fdNop, deNop, deHold;
  logic [15:0] stallCnt, flushCnt;

  logic        sPcEn, sFdHold, sFdNop, sDeNop, sDeHold;
  logic [2:0]  sStallCnt, sFlushCnt;

  int checkCount = 0;
  int passCount  = 0;

  pipeline_hazard_controller dut (
    .clk             (clk),
    .reset           (reset),
    .dec_rs1         (decRs1),
    .dec_rs2         (decRs2),
    .dec_use_rs1     (decUseRs1),
    .dec_use_rs2     (decUseRs2),
    .ex_rd           (exRd),
    .ex_mem_read     (exMemRead),
    .ex_branch_taken (exBranchTaken),
    .mem_busy        (memBusy),
    .pc_en           (pcEn),
    .fd_hold         (fdHold),
    .fd_nop          (fdNop),
    .de_nop          (deNop),
    .de_hold         (deHold),
    .stall_cnt       (stallCnt),
    .flush_cnt       (flushCnt)
  );

  pipeline_hazard_controller #(
    .LOAD_STALL_CYC (3),
    .PERF_W         (3)
  ) dutSmall (
    .clk             (clk),
    .reset           (reset),
    .dec_rs1         (decRs1),
    .dec_rs2         (decRs2),
    .dec_use_rs1     (decUseRs1),
    .dec_use_rs2     (decUseRs2),
    .ex_rd           (exRd),
    .ex_mem_read     (exMemRead),
    .ex_branch_taken (exBranchTaken),
    .mem_busy        (memBusy),
    .pc_en           (sPcEn),
    .fd_hold         (sFdHold),
    .fd_nop          (sFdNop),
    .de_nop          (sDeNop),
    .de_hold         (sDeHold),
    .stall_cnt       (sStallCnt),
    .flush_cnt       (sFlushCnt)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic use1, input logic use2,
                               input logic [3:0] rd, input logic memRead,
                               input logic branch, input logic busy);
    decRs1        = rs1;
    decRs2        = rs2;
    decUseRs1     = use1;
    decUseRs2     = use2;
    exRd          = rd;
    exMemRead     = memRead;
    exBranchTaken = branch;
    memBusy       = busy;
  endtask

  task automatic applyIdle();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    reset = 1'b0;
    applyIdle();
    repeat (2) stepCycle();
    reset = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    reset = 1'b0;
    applyIdle();

    // Reset held three cycles, then released
    repeat (3) stepCycle();
    checkOutput("rst_pc_en", pcEn, 0);
    checkOutput("rst_fd_nop", fdNop, 1);
    checkOutput("rst_de_nop", deNop, 1);
    checkOutput("rst_fd_hold", fdHold, 0);
    checkOutput("rst_de_hold", deHold, 0);
    reset = 1'b1;
    #1;
    checkOutput("run_pc_en", pcEn, 1);
    checkOutput("run_fd_nop", fdNop, 0);
    checkOutput("run_stall_cnt", stallCnt, 0);
    checkOutput("run_flush_cnt", flushCnt, 0);
    stepCycle();

    // Load-use on rs1
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lu1_pc_en", pcEn, 0);
    checkOutput("lu1_fd_hold", fdHold, 1);
    checkOutput("lu1_de_nop", deNop, 1);
    checkOutput("lu1_fd_nop", fdNop, 0);
    checkOutput("lu1_de_hold", deHold, 0);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("lu1_after_pc_en", pcEn, 1);
    checkOutput("lu1_after_fd_hold", fdHold, 0);
    checkOutput("lu1_stall_cnt", stallCnt, 1);
    stepCycle();

    // Load-use on rs2 only
    applyStimulus(4'd5, 4'd5, 1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("lu2_pc_en", pcEn, 0);
    checkOutput("lu2_fd_hold", fdHold, 1);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("lu2_stall_cnt", stallCnt, 2);
    stepCycle();

    // Near-misses that must not stall
    applyStimulus(4'd3, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("nh_unused_pc_en", pcEn, 1);
    checkOutput("nh_unused_fd_hold", fdHold, 0);
    checkOutput("nh_unused_de_nop", deNop, 0);
    stepCycle();
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("nh_noload_fd_hold", fdHold, 0);
    stepCycle();
    applyStimulus(4'd3, 4'd6, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("nh_diffreg_pc_en", pcEn, 1);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("nh_stall_cnt", stallCnt, 2);

    // Taken branch: two flush cycles, bubble on the first only
    applyReset();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("br_pc_en", pcEn, 1);
    checkOutput("br_fd_nop", fdNop, 1);
    checkOutput("br_de_nop", deNop, 1);
    checkOutput("br_fd_hold", fdHold, 0);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("br_fl_pc_en", pcEn, 1);
    checkOutput("br_fl_fd_nop", fdNop, 1);
    checkOutput("br_fl_de_nop", deNop, 0);
    stepCycle();
    #1;
    checkOutput("br_done_fd_nop", fdNop, 0);
    checkOutput("br_flush_cnt", flushCnt, 2);

    // Branch wins over memory busy and a load-use hazard
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, 1'b1);
    #1;
    checkOutput("brpri_pc_en", pcEn, 1);
    checkOutput("brpri_fd_hold", fdHold, 0);
    checkOutput("brpri_de_hold", deHold, 0);
    checkOutput("brpri_fd_nop", fdNop, 1);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("brpri_fl_fd_nop", fdNop, 1);
    stepCycle();
    #1;
    checkOutput("brpri_flush_cnt", flushCnt, 4);
    checkOutput("brpri_stall_cnt", stallCnt, 0);

    // Three-cycle stall on the long-stall instance
    applyReset();
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("s_st1_pc_en", sPcEn, 0);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("s_st2_pc_en", sPcEn, 0);
    checkOutput("s_st2_fd_hold", sFdHold, 1);
    stepCycle();
    #1;
    checkOutput("s_st3_pc_en", sPcEn, 0);
    stepCycle();
    #1;
    checkOutput("s_st_done_pc_en", sPcEn, 1);
    checkOutput("s_st_stall_cnt", sStallCnt, 3);
    stepCycle();

    // Branch on the second stall cycle abandons the stall
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    #1;
    checkOutput("s_brst_pc_en", sPcEn, 1);
    checkOutput("s_brst_fd_nop", sFdNop, 1);
    checkOutput("s_brst_fd_hold", sFdHold, 0);
    checkOutput("s_brst_de_nop", sDeNop, 1);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("s_brst_fl_fd_nop", sFdNop, 1);
    checkOutput("s_brst_fl_de_nop", sDeNop, 0);
    stepCycle();
    #1;
    checkOutput("s_brst_run_pc_en", sPcEn, 1);
    checkOutput("s_brst_run_fd_hold", sFdHold, 0);
    checkOutput("s_brst_stall_cnt", sStallCnt, 4);
    checkOutput("s_brst_flush_cnt", sFlushCnt, 2);

    // Memory freeze for four cycles with a hazard pending behind it
    applyReset();
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput("frz_pc_en", pcEn, 0);
      checkOutput("frz_fd_hold", fdHold, 1);
      checkOutput("frz_de_hold", deHold, 1);
      checkOutput("frz_de_nop", deNop, 0);
      stepCycle();
    end
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("frz_st_pc_en", pcEn, 0);
    checkOutput("frz_st_fd_hold", fdHold, 1);
    checkOutput("frz_st_de_nop", deNop, 1);
    checkOutput("frz_st_de_hold", deHold, 0);
    stepCycle();
    applyIdle();
    #1;
    checkOutput("frz_run_pc_en", pcEn, 1);
    checkOutput("frz_stall_cnt", stallCnt, 5);
    stepCycle();
    stepCycle();
    #1;
    checkOutput("s_frz_run_pc_en", sPcEn, 1);
    checkOutput("s_frz_stall_cnt", sStallCnt, 7);

    // Stall counter saturation on the narrow instance
    applyStimulus(4'd3, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
    stepCycle();
    applyIdle();
    stepCycle();
    stepCycle();
    #1;
    checkOutput("s_sat_stall_cnt", sStallCnt, 7);
    checkOutput("s_sat_pc_en", sPcEn, 1);
    checkOutput("sat_stall_cnt", stallCnt, 6);

    // Flush counter saturation on the narrow instance
    repeat (4) begin
      applyStimulus(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      stepCycle();
      applyIdle();
      stepCycle();
    end
    #1;
    checkOutput("s_sat_flush_cnt", sFlushCnt, 7);
    checkOutput("sat_flush_cnt", flushCnt, 8);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
